intc_route_sched: RTL and testbench
===================================

INTC_ROUTE_SCHED -- requirements
Module: intc_route_sched

Interface
REQ-001 Parameter NUM_REQ, default 4: number of transfer requesters.
REQ-002 Parameter STAGE_NUM, default package STAGE_NUM (9): interconnect pipeline stages.
REQ-003 Parameter SLOT_NUM, default package SLOT_NUM (20): buffer RAM slots.
REQ-004 Parameter MODULE_NUM, default package MODULE_NUM (20): arithmetic modules.
REQ-005 One clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  system clock, all state on rising edge.
REQ-007 rstn  in  1  asynchronous active-low reset.
REQ-008 req_valid  in  NUM_REQ  per-requester transfer request, level.
REQ-009 req_slot  in  NUM_REQ*5  buffer slot index per requester.
REQ-010 req_module  in  NUM_REQ*5  module index per requester.
REQ-011 req_len  in  NUM_REQ*16  beat count per requester.
REQ-012 grant  out  NUM_REQ  one-cycle pulse: request accepted.
REQ-013 done  out  NUM_REQ  one-cycle pulse: last beat left final stage.
REQ-014 err  out  1  one-cycle pulse: accepted request was illegal.
REQ-015 module_select  out  STAGE_NUM*16  per-stage select, bit15 valid, [4:0] module index, others 0.
REQ-016 slot_select  out  STAGE_NUM*16  per-stage select, same encoding with slot index.
REQ-017 busy  out  1  high while RUN or any stage holds a valid beat.

Function
REQ-018 FSM states IDLE, RUN; reset state IDLE.
REQ-019 Arbitration: round-robin over asserted req_valid starting at rr_ptr; rr_ptr becomes winner+1 mod NUM_REQ after each grant.
REQ-020 Arbitration happens in IDLE, and in RUN on the cycle the last beat issues (zero-bubble back-to-back).
REQ-021 Winner gets grant pulse in grant cycle G; slot, module, len latched at G; later input changes ignored.
REQ-022 Illegal request (slot>=SLOT_NUM, module>=MODULE_NUM, or len==0): grant and err pulse at G, no beats, no done, FSM unchanged.
REQ-023 Legal request: FSM to RUN; one beat per cycle at stage 0 in cycles G+1..G+len.
REQ-024 Stage s shows a beat s cycles after stage 0; selects and requester tag shift one stage per cycle.
REQ-025 Stage with no beat drives select 16'h0000.
REQ-026 done[id] pulses at cycle G+len+STAGE_NUM (cycle after last beat at stage STAGE_NUM-1).
REQ-027 RUN returns to IDLE after last beat unless a new grant occurs that cycle.
REQ-028 Beat counter 16-bit, decrements per beat; len 16'hFFFF yields 65535 beats without wrap.
REQ-029 At most one grant per cycle; grant of a new transfer may coincide with done of an earlier one.

Reset
REQ-030 rstn low: FSM IDLE, rr_ptr 0, counter 0, all stage registers 0, grant/done/err/busy 0.
REQ-031 Reset mid-transfer discards in-flight beats; no done issued for them after release.
REQ-032 First grant possible on first rising edge after rstn deasserts.

Structure
REQ-033 Package gains select-encoding constants (SEL_VALID_BIT=15, SEL_IDX_W=5) and a packed route-request typedef (slot, module, len).
REQ-034 Round-robin arbiter is one sub-module, intc_rr_arbiter; stage shift pipeline stays in intc_route_sched.

Verification
REQ-035 Req0 slot 3 module 7 len 4 at G=10 -> stage0 selects 16'h8003/16'h8007 cycles 11-14; stage8 cycles 19-22; done[0] cycle 23.
REQ-036 Req0..3 all asserted at reset release, len 2 each -> grants 0,1,2,3 at cycles G, G+2, G+4, G+6; no stage-0 bubble.
REQ-037 Req1 slot 20 -> grant[1]+err same cycle, selects stay 0, no done[1].
REQ-038 Req2 len 0 -> grant+err, FSM stays IDLE, busy stays 0.
REQ-039 rstn low at G+3 of len-8 transfer -> all selects 0 immediately, no done after release.
REQ-040 rr_ptr=2, req0 and req3 valid -> req3 granted first, then req0.

Source files
------------

// File: rtl/intc_route_sched_pkg.sv
// Shared constants and types for the interconnect route scheduler.
// The select encoding is {valid, 10'b0, index} on a 16-bit bus.
package intc_route_sched_pkg;

    localparam int STAGE_NUM     = 9;
    localparam int SLOT_NUM      = 20;
    localparam int MODULE_NUM    = 20;
    localparam int SEL_W         = 16;
    localparam int SEL_VALID_BIT = 15;
    localparam int SEL_IDX_W     = 5;
    localparam int LEN_W         = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } sched_state_t;

    typedef struct packed {
        logic [SEL_IDX_W-1:0] slot;
        logic [SEL_IDX_W-1:0] mod;
        logic [LEN_W-1:0]     len;
    } route_req_t;

    function automatic logic [SEL_W-1:0] make_sel(input logic vld, input logic [SEL_IDX_W-1:0] idx);
        logic [SEL_W-1:0] sel;
        sel = '0;
        if (vld) begin
            sel[SEL_VALID_BIT]   = 1'b1;
            sel[SEL_IDX_W-1:0]   = idx;
        end
        return sel;
    endfunction

endpackage

// File: rtl/intc_rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or after the
// pointer; the pointer moves past the winner whenever a grant is taken.
module intc_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_take,
    output logic               o_any,
    output logic [IDW-1:0]     o_idx,
    output logic [NUM_REQ-1:0] o_onehot
);

    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] w_next_ptr;

    // Scan from the far end back toward the pointer so the last hit wins.
    always_comb begin
        int p;
        p        = 0;
        o_any    = 1'b0;
        o_idx    = '0;
        o_onehot = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            p = int'(r_ptr) + k;
            if (p >= NUM_REQ) begin
                p = p - NUM_REQ;
            end
            if (i_req[p[IDW-1:0]]) begin
                o_any = 1'b1;
                o_idx = p[IDW-1:0];
            end
        end
        if (o_any) begin
            o_onehot[o_idx] = 1'b1;
        end
    end

    assign w_next_ptr = (int'(o_idx) == NUM_REQ - 1) ? '0 : o_idx + 1'b1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ptr <= '0;
        end else if (i_take) begin
            r_ptr <= w_next_ptr;
        end
    end

endmodule

// File: rtl/intc_route_sched.sv
// Transfer scheduler: arbitrates requesters, issues one beat per cycle into
// a STAGE_NUM-deep select pipeline and reports completion per requester.
module intc_route_sched #(
    parameter int NUM_REQ    = 4,
    parameter int STAGE_NUM  = intc_route_sched_pkg::STAGE_NUM,
    parameter int SLOT_NUM   = intc_route_sched_pkg::SLOT_NUM,
    parameter int MODULE_NUM = intc_route_sched_pkg::MODULE_NUM
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*5-1:0]    req_slot,
    input  logic [NUM_REQ*5-1:0]    req_module,
    input  logic [NUM_REQ*16-1:0]   req_len,
    output logic [NUM_REQ-1:0]      grant,
    output logic [NUM_REQ-1:0]      done,
    output logic                    err,
    output logic [STAGE_NUM*16-1:0] module_select,
    output logic [STAGE_NUM*16-1:0] slot_select,
    output logic                    busy
);

    import intc_route_sched_pkg::*;

    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef struct packed {
        logic                 vld;
        logic                 last;
        logic [IDW-1:0]       tag;
        logic [SEL_IDX_W-1:0] slot;
        logic [SEL_IDX_W-1:0] mod;
    } stage_t;

    sched_state_t          r_state;
    sched_state_t          w_state_next;
    logic [LEN_W-1:0]      r_cnt;
    logic [SEL_IDX_W-1:0]  r_cur_slot;
    logic [SEL_IDX_W-1:0]  r_cur_mod;
    logic [IDW-1:0]        r_cur_id;
    logic [NUM_REQ-1:0]    r_grant;
    logic [NUM_REQ-1:0]    r_done;
    logic                  r_err;

    logic                  w_any;
    logic [IDW-1:0]        w_win;
    logic [NUM_REQ-1:0]    w_win_oh;
    route_req_t            w_win_req;
    logic                  w_beat;
    logic                  w_last_beat;
    logic                  w_arb_en;
    logic                  w_take;
    logic                  w_legal;
    logic [STAGE_NUM-1:0]  w_stg_vld;
    stage_t                w_tail;

    intc_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_arb (
        .clk      (clk),
        .rstn     (rstn),
        .i_req    (req_valid),
        .i_take   (w_take),
        .o_any    (w_any),
        .o_idx    (w_win),
        .o_onehot (w_win_oh)
    );

    assign w_win_req = {req_slot[int'(w_win)*SEL_IDX_W +: SEL_IDX_W],
                        req_module[int'(w_win)*SEL_IDX_W +: SEL_IDX_W],
                        req_len[int'(w_win)*LEN_W +: LEN_W]};

    assign w_beat      = (r_state == ST_RUN);
    assign w_last_beat = w_beat && (r_cnt == 16'd1);
    // Re-arbitrating on the last beat lets the next transfer follow without a gap.
    assign w_arb_en    = (r_state == ST_IDLE) || w_last_beat;
    assign w_take      = w_arb_en && w_any;
    assign w_legal     = (int'(w_win_req.slot) < SLOT_NUM) &&
                         (int'(w_win_req.mod) < MODULE_NUM) &&
                         (w_win_req.len != '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_take && w_legal) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last_beat) begin
                    w_state_next = (w_take && w_legal) ? ST_RUN : ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt      <= '0;
            r_cur_slot <= '0;
            r_cur_mod  <= '0;
            r_cur_id   <= '0;
            r_grant    <= '0;
            r_err      <= 1'b0;
        end else begin
            r_grant <= w_take ? w_win_oh : '0;
            r_err   <= w_take && !w_legal;
            if (w_beat) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_take && w_legal) begin
                r_cnt      <= w_win_req.len;
                r_cur_slot <= w_win_req.slot;
                r_cur_mod  <= w_win_req.mod;
                r_cur_id   <= w_win;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < STAGE_NUM; gi++) begin : g_stage
            stage_t r_stg;
            if (gi == 0) begin : g_head
                always_ff @(posedge clk or negedge rstn) begin
                    if (!rstn) begin
                        r_stg <= '0;
                    end else begin
                        r_stg.vld  <= w_beat;
                        r_stg.last <= w_last_beat;
                        r_stg.tag  <= w_beat ? r_cur_id   : '0;
                        r_stg.slot <= w_beat ? r_cur_slot : '0;
                        r_stg.mod  <= w_beat ? r_cur_mod  : '0;
                    end
                end
            end else begin : g_body
                always_ff @(posedge clk or negedge rstn) begin
                    if (!rstn) begin
                        r_stg <= '0;
                    end else begin
                        r_stg <= g_stage[gi-1].r_stg;
                    end
                end
            end
            assign w_stg_vld[gi]                = r_stg.vld;
            assign module_select[gi*16 +: 16]   = make_sel(r_stg.vld, r_stg.mod);
            assign slot_select[gi*16 +: 16]     = make_sel(r_stg.vld, r_stg.slot);
        end
    endgenerate

    assign w_tail = g_stage[STAGE_NUM-1].r_stg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_done <= '0;
        end else begin
            r_done <= '0;
            if (w_tail.vld && w_tail.last) begin
                r_done[w_tail.tag] <= 1'b1;
            end
        end
    end

    assign grant = r_grant;
    assign done  = r_done;
    assign err   = r_err;
    assign busy  = (r_state == ST_RUN) || (|w_stg_vld);

endmodule

// File: tb/tb_intc_route_sched.sv
// Bench for intc_route_sched: vector table of single transfers, directed
// multi-cycle sequences, and random traffic against a schedule-based model.
module tb_intc_route_sched;

    import intc_route_sched_pkg::*;

    localparam int N  = 4;
    localparam int ST = STAGE_NUM;
    localparam int R  = 64;

    logic                clk = 1'b0;
    logic                rstn;
    logic [N-1:0]        req_valid;
    logic [N*5-1:0]      req_slot;
    logic [N*5-1:0]      req_module;
    logic [N*16-1:0]     req_len;
    logic [N-1:0]        grant;
    logic [N-1:0]        done;
    logic                err;
    logic [ST*16-1:0]    module_select;
    logic [ST*16-1:0]    slot_select;
    logic                busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    intc_route_sched #(.NUM_REQ(N)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .req_valid     (req_valid),
        .req_slot      (req_slot),
        .req_module    (req_module),
        .req_len       (req_len),
        .grant         (grant),
        .done          (done),
        .err           (err),
        .module_select (module_select),
        .slot_select   (slot_select),
        .busy          (busy)
    );

    typedef struct {
        int          id;
        int          slot;
        int          md;
        int          len;
        logic        exp_err;
        logic [15:0] exp_m;
        logic [15:0] exp_s;
        int          exp_beats;
        int          exp_done;
        logic        exp_busy;
    } vec_t;

    vec_t vt [7];

    logic [ST*16-1:0] em [R];
    logic [ST*16-1:0] es [R];
    logic [N-1:0]     ed [R];
    logic             eb [R];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input int slot, input int md, input int len, input logic v);
        req_slot[id*5 +: 5]    = 5'(slot);
        req_module[id*5 +: 5]  = 5'(md);
        req_len[id*16 +: 16]   = 16'(len);
        req_valid[id]          = v;
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        req_valid = '0;
        step();
        step();
        rstn = 1'b1;
    endtask

    task automatic run_vec(input int i);
        int          g_seen;
        int          beats;
        int          s8_first;
        int          done_off;
        int          extra;
        logic        busy_seen;
        logic        legal;
        logic [15:0] s0m;
        logic [15:0] s0s;
        legal = !vt[i].exp_err;
        set_req(vt[i].id, vt[i].slot, vt[i].md, vt[i].len, 1'b1);
        g_seen = 0;
        for (int w = 0; w < 4 && g_seen == 0; w++) begin
            step();
            if (grant != '0) g_seen = 1;
        end
        chk($sformatf("vec%0d/grant", i), 256'(grant), 256'(1) << vt[i].id);
        chk($sformatf("vec%0d/err", i), 256'(err), 256'(vt[i].exp_err));
        req_valid[vt[i].id] = 1'b0;
        beats = 0; s8_first = 0; done_off = 0; extra = 0;
        busy_seen = busy;
        s0m = '0; s0s = '0;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (module_select[15]) begin
                beats++;
                s0m = module_select[15:0];
                s0s = slot_select[15:0];
            end
            if (module_select[(ST-1)*16+15] && s8_first == 0) s8_first = k;
            if (done[vt[i].id] && done_off == 0) done_off = k;
            if (grant != '0 || err) extra++;
            busy_seen = busy_seen | busy;
        end
        chk($sformatf("vec%0d/beats", i), 256'(beats), 256'(vt[i].exp_beats));
        chk($sformatf("vec%0d/s0_module", i), 256'(s0m), 256'(vt[i].exp_m));
        chk($sformatf("vec%0d/s0_slot", i), 256'(s0s), 256'(vt[i].exp_s));
        chk($sformatf("vec%0d/s_last_first", i), 256'(s8_first), 256'(legal ? ST : 0));
        chk($sformatf("vec%0d/done_off", i), 256'(done_off), 256'(vt[i].exp_done));
        chk($sformatf("vec%0d/stray", i), 256'(extra), 256'(0));
        chk($sformatf("vec%0d/busy", i), 256'(busy_seen), 256'(vt[i].exp_busy));
    endtask

    task automatic run_random(input int ncyc);
        int            ptr;
        int            arb_free;
        int            w;
        int            p;
        int            slot_i;
        int            md_i;
        int            len_i;
        logic [N-1:0]  mv;
        logic [N-1:0]  exp_g;
        logic          exp_e;
        int            ri;
        for (int k = 0; k < R; k++) begin
            em[k] = '0; es[k] = '0; ed[k] = '0; eb[k] = 1'b0;
        end
        do_reset();
        ptr = 0;
        arb_free = 0;
        for (int c = 1; c <= ncyc; c++) begin
            mv = req_valid;
            step();
            exp_g = '0;
            exp_e = 1'b0;
            if (c >= arb_free && mv != '0) begin
                w = -1;
                for (int k = 0; k < N; k++) begin
                    p = (ptr + k) % N;
                    if (w < 0 && mv[p]) w = p;
                end
                exp_g[w] = 1'b1;
                ptr = (w + 1) % N;
                slot_i = int'(req_slot[w*5 +: 5]);
                md_i   = int'(req_module[w*5 +: 5]);
                len_i  = int'(req_len[w*16 +: 16]);
                if (slot_i >= SLOT_NUM || md_i >= MODULE_NUM || len_i == 0) begin
                    exp_e    = 1'b1;
                    arb_free = c + 1;
                end else begin
                    arb_free = c + len_i;
                    for (int k = 1; k <= len_i; k++) begin
                        for (int s = 0; s < ST; s++) begin
                            em[(c+k+s)%R][s*16 +: 16] = {1'b1, 10'b0, 5'(md_i)};
                            es[(c+k+s)%R][s*16 +: 16] = {1'b1, 10'b0, 5'(slot_i)};
                        end
                    end
                    for (int k = c; k < c + len_i + ST; k++) eb[k%R] = 1'b1;
                    ed[(c+len_i+ST)%R][w] = 1'b1;
                end
            end
            ri = c % R;
            chk("rnd/grant", 256'(grant), 256'(exp_g));
            chk("rnd/err", 256'(err), 256'(exp_e));
            chk("rnd/done", 256'(done), 256'(ed[ri]));
            chk("rnd/module_select", 256'(module_select), 256'(em[ri]));
            chk("rnd/slot_select", 256'(slot_select), 256'(es[ri]));
            chk("rnd/busy", 256'(busy), 256'(eb[ri]));
            em[ri] = '0; es[ri] = '0; ed[ri] = '0; eb[ri] = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (exp_g[i]) begin
                    req_valid[i] = 1'b0;
                end else if (!req_valid[i] && c < ncyc - 30 && $urandom_range(0, 3) == 0) begin
                    len_i = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
                    set_req(i, int'($urandom_range(0, 23)), int'($urandom_range(0, 23)), len_i, 1'b1);
                end
            end
        end
        req_valid = '0;
    endtask

    initial begin
        int gcyc [N];
        int s0_beats;
        int s0_first;
        int s0_last;
        int g0;
        int g3;
        int bad_out;
        int beats;
        int done_off;

        vt[0] = '{0,  3,  7, 4, 1'b0, 16'h8007, 16'h8003, 4, 4 + ST, 1'b1};
        vt[1] = '{1, 20,  5, 3, 1'b1, 16'h0000, 16'h0000, 0, 0,      1'b0};
        vt[2] = '{2,  4,  6, 0, 1'b1, 16'h0000, 16'h0000, 0, 0,      1'b0};
        vt[3] = '{3, 19, 19, 1, 1'b0, 16'h8013, 16'h8013, 1, 1 + ST, 1'b1};
        vt[4] = '{0,  0, 20, 2, 1'b1, 16'h0000, 16'h0000, 0, 0,      1'b0};
        vt[5] = '{2, 31, 31, 5, 1'b1, 16'h0000, 16'h0000, 0, 0,      1'b0};
        vt[6] = '{1,  0,  0, 7, 1'b0, 16'h8000, 16'h8000, 7, 7 + ST, 1'b1};

        rstn       = 1'b0;
        req_valid  = '0;
        req_slot   = '0;
        req_module = '0;
        req_len    = '0;
        step();
        chk("rst/grant", 256'(grant), 256'(0));
        chk("rst/done", 256'(done), 256'(0));
        chk("rst/err", 256'(err), 256'(0));
        chk("rst/busy", 256'(busy), 256'(0));
        chk("rst/module_select", 256'(module_select), 256'(0));
        chk("rst/slot_select", 256'(slot_select), 256'(0));
        rstn = 1'b1;
        step();

        for (int i = 0; i < 7; i++) run_vec(i);

        // All four requesters waiting across reset release, len 2 each.
        rstn = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, i + 1, i + 10, 2, 1'b1);
        step();
        rstn = 1'b1;
        for (int i = 0; i < N; i++) gcyc[i] = -1;
        s0_beats = 0; s0_first = -1; s0_last = -1;
        for (int k = 1; k <= 20; k++) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (grant[i]) begin
                    gcyc[i] = k;
                    req_valid[i] = 1'b0;
                end
            end
            if (module_select[15]) begin
                s0_beats++;
                if (s0_first < 0) s0_first = k;
                s0_last = k;
            end
        end
        chk("b2b/grant0", 256'(gcyc[0]), 256'(1));
        chk("b2b/grant1", 256'(gcyc[1]), 256'(3));
        chk("b2b/grant2", 256'(gcyc[2]), 256'(5));
        chk("b2b/grant3", 256'(gcyc[3]), 256'(7));
        chk("b2b/s0_beats", 256'(s0_beats), 256'(8));
        chk("b2b/s0_span", 256'(s0_last - s0_first + 1), 256'(8));

        // Pointer to 2 via an illegal grant to req1, then req0 and req3 compete.
        do_reset();
        set_req(1, 1, 1, 0, 1'b1);
        step();
        chk("rr/illegal_grant", 256'(grant), 256'(4'b0010));
        chk("rr/illegal_err", 256'(err), 256'(1));
        chk("rr/illegal_busy", 256'(busy), 256'(0));
        req_valid[1] = 1'b0;
        step();
        set_req(0, 2, 2, 1, 1'b1);
        set_req(3, 5, 5, 1, 1'b1);
        g0 = -1; g3 = -1;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (grant[0]) begin g0 = k; req_valid[0] = 1'b0; end
            if (grant[3]) begin g3 = k; req_valid[3] = 1'b0; end
        end
        chk("rr/req3_first", 256'(g3), 256'(1));
        chk("rr/req0_second", 256'(g0), 256'(2));
        for (int k = 0; k < 14; k++) step();

        // Reset three cycles into a len-8 transfer.
        set_req(0, 6, 9, 8, 1'b1);
        step();
        chk("rstmid/grant", 256'(grant), 256'(1));
        req_valid[0] = 1'b0;
        step(); step(); step();
        chk("rstmid/inflight", 256'(module_select[15:0]), 256'(16'h8009));
        rstn = 1'b0;
        #1;
        chk("rstmid/module_select", 256'(module_select), 256'(0));
        chk("rstmid/slot_select", 256'(slot_select), 256'(0));
        chk("rstmid/busy", 256'(busy), 256'(0));
        step(); step();
        rstn = 1'b1;
        bad_out = 0;
        for (int k = 0; k < 25; k++) begin
            step();
            if (done != '0 || module_select != '0 || busy) bad_out++;
        end
        chk("rstmid/after_release", 256'(bad_out), 256'(0));

        // Maximum length: 65535 beats, no counter wrap.
        set_req(2, 1, 2, 16'hFFFF, 1'b1);
        step();
        chk("maxlen/grant", 256'(grant), 256'(4'b0100));
        req_valid[2] = 1'b0;
        beats = 0; done_off = 0;
        for (int k = 1; k <= 65535 + ST + 6; k++) begin
            step();
            if (module_select[15]) beats++;
            if (done[2] && done_off == 0) done_off = k;
        end
        chk("maxlen/beats", 256'(beats), 256'(65535));
        chk("maxlen/done_off", 256'(done_off), 256'(65535 + ST));

        run_random(2000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
